cordic_ctrl: RTL and testbench

//  Upstream control stage for the cordic core: accepts x/y/z/mode operand sets via a

---
 rtl/cordic_ctrl.sv | 158 +++++++++++++++
 tb/tb_cordic_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_ctrl.sv
// rtl/cordic_ctrl.sv - operand folding, core sequencing and result hand-off for the cordic core
module cordic_ctrl #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int CORE_LAT = 16,
  parameter logic signed [WIDTH-1:0] PI_2 =
    WIDTH'((FRAC >= 8) ? (402 << (FRAC - 8)) : (402 >> (8 - FRAC))),
  parameter logic signed [WIDTH-1:0] PI =
    WIDTH'((FRAC >= 8) ? (804 << (FRAC - 8)) : (804 >> (8 - FRAC)))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [WIDTH-1:0] in_z,
  output logic                    core_mode,
  output logic signed [WIDTH-1:0] core_x,
  output logic signed [WIDTH-1:0] core_y,
  output logic signed [WIDTH-1:0] core_z,
  output logic                    core_reset,
  input  logic signed [WIDTH-1:0] core_res1,
  input  logic signed [WIDTH-1:0] core_res2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_res1,
  output logic signed [WIDTH-1:0] out_res2,
  output logic                    out_folded
);

  localparam int CNT_W = $clog2(CORE_LAT + 1);
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] NEG_PI_2 = -PI_2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_core_mode;
  logic signed [WIDTH-1:0]  r_core_x;
  logic signed [WIDTH-1:0]  r_core_y;
  logic signed [WIDTH-1:0]  r_core_z;
  logic                     r_fold;
  logic                     r_out_valid;
  logic signed [WIDTH-1:0]  r_out_res1;
  logic signed [WIDTH-1:0]  r_out_res2;
  logic                     r_out_folded;

  logic signed [WIDTH-1:0]  w_x;
  logic signed [WIDTH-1:0]  w_y;
  logic signed [WIDTH-1:0]  w_z;
  logic                     w_fold;

  // Negation that clamps the most negative value instead of wrapping back onto itself
  function automatic logic signed [WIDTH-1:0] f_neg(input logic signed [WIDTH-1:0] v);
    if (v == S_MIN) begin
      return S_MAX;
    end
    return -v;
  endfunction

  // Fold the incoming operand set into the core's +-pi/2 convergence range
  always_comb begin
    w_x    = in_x;
    w_y    = in_y;
    w_z    = in_z;
    w_fold = 1'b0;
    if (in_mode) begin
      if (in_z > PI_2) begin
        w_x    = f_neg(in_x);
        w_y    = f_neg(in_y);
        w_z    = in_z - PI;
        w_fold = 1'b1;
      end else if (in_z < NEG_PI_2) begin
        w_x    = f_neg(in_x);
        w_y    = f_neg(in_y);
        w_z    = in_z + PI;
        w_fold = 1'b1;
      end
    end else if (in_x[WIDTH-1]) begin
      w_x    = f_neg(in_x);
      w_y    = f_neg(in_y);
      w_z    = in_y[WIDTH-1] ? (in_z - PI) : (in_z + PI);
      w_fold = 1'b1;
    end
  end

  // Controller FSM: accept, pulse core reset, wait core latency, hold result until popped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_core_mode  <= 1'b0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_core_z     <= '0;
      r_fold       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_res1   <= '0;
      r_out_res2   <= '0;
      r_out_folded <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_core_mode <= in_mode;
            r_core_x    <= w_x;
            r_core_y    <= w_y;
            r_core_z    <= w_z;
            r_fold      <= w_fold;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(CORE_LAT - 1)) begin
            r_out_res1   <= core_res1;
            r_out_res2   <= core_res2;
            r_out_folded <= r_fold;
            r_out_valid  <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign core_reset = reset & (r_state != LOAD);
  assign core_mode  = r_core_mode;
  assign core_x     = r_core_x;
  assign core_y     = r_core_y;
  assign core_z     = r_core_z;
  assign out_valid  = r_out_valid;
  assign out_res1   = r_out_res1;
  assign out_res2   = r_out_res2;
  assign out_folded = r_out_folded;

endmodule

// File: tb/tb_cordic_ctrl.sv
// tb/tb_cordic_ctrl.sv - directed bench for cordic_ctrl with a stub core
module tb_cordic_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_x, in_y, in_z;
  logic        core_mode;
  logic [15:0] core_x, core_y, core_z;
  logic        core_reset;
  logic [15:0] core_res1, core_res2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res1, out_res2;
  logic        out_folded;

  int total = 0;
  int bad   = 0;
  int n, lows;
  logic [15:0] held1, held2;

  always #5 clk = ~clk;

  cordic_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .core_mode(core_mode), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_reset(core_reset), .core_res1(core_res1), .core_res2(core_res2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res1(out_res1), .out_res2(out_res2), .out_folded(out_folded)
  );

  // Stub core: results are only meaningful once 15 clocks have elapsed after reset release
  logic [7:0] core_cnt;
  always @(posedge clk) begin
    if (!core_reset) core_cnt <= 8'd0;
    else if (core_cnt != 8'hFF) core_cnt <= core_cnt + 8'd1;
  end
  assign core_res1 = (core_cnt >= 8'd15) ? (core_x ^ 16'h00FF) : 16'hDEAD;
  assign core_res2 = (core_cnt >= 8'd15) ? core_z : 16'hBEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one operand set in IDLE; returns at the negedge after the accept edge (LOAD)
  task automatic accept(input logic m, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_mode = m; in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_core(input string tag, input logic m, input logic [15:0] x,
                             input logic [15:0] y, input logic [15:0] z);
    check({tag, "_mode"}, core_mode, m);
    check({tag, "_x"}, core_x, x);
    check({tag, "_y"}, core_y, y);
    check({tag, "_z"}, core_z, z);
  endtask

  // Count negedges (from LOAD) until out_valid, plus how many of them had core_reset low
  task automatic wait_valid(output int cnt, output int lo);
    cnt = 0;
    lo  = 0;
    while (!out_valid && cnt < 60) begin
      if (!core_reset) lo++;
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [15:0] r1, input logic [15:0] r2,
                               input logic f);
    wait_valid(n, lows);
    check({tag, "_lat"}, n, 17);
    check({tag, "_coreRstLow"}, lows, 1);
    check({tag, "_res1"}, out_res1, r1);
    check({tag, "_res2"}, out_res2, r2);
    check({tag, "_folded"}, out_folded, f);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_x = 16'h0; in_y = 16'h0; in_z = 16'h0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res1", out_res1, 16'h0);
    check("rst_folded", out_folded, 1'b0);
    check("rst_core_x", core_x, 16'h0);
    check("rst_core_mode", core_mode, 1'b0);
    check("rst_core_reset", core_reset, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("core_reset_idle", core_reset, 1'b1);

    // Rotation fold by pi
    accept(1'b1, 16'hF994, 16'h1EC1, 16'h0200);
    expect_core("rot", 1'b1, 16'h066C, 16'hE13F, 16'hFEDC);
    check("rot_in_ready_load", in_ready, 1'b0);
    expect_result("rot", 16'h0693, 16'hFEDC, 1'b1);
    @(negedge clk);
    check("rot_valid_fall", out_valid, 1'b0);
    check("rot_idle_ready", in_ready, 1'b1);

    // Vectoring fold with backpressure; a pending operand set must not sneak in
    out_ready = 1'b0;
    accept(1'b0, 16'hFF00, 16'h0000, 16'h0000);
    expect_core("vec", 1'b0, 16'h0100, 16'h0000, 16'h0324);
    expect_result("vec", 16'h01FF, 16'h0324, 1'b1);
    held1 = out_res1; held2 = out_res2;
    in_mode = 1'b1; in_x = 16'h1234; in_y = 16'h0; in_z = 16'h0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_res1", out_res1, held1);
      check("bp_res2", out_res2, held2);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_core_x", core_x, 16'h0100);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop", out_valid, 1'b0);

    // Vectoring with negative y folds the other way
    accept(1'b0, 16'hFF00, 16'hFFFF, 16'h0000);
    expect_core("vecneg", 1'b0, 16'h0100, 16'h0001, 16'hFCDC);
    expect_result("vecneg", 16'h01FF, 16'hFCDC, 1'b1);

    // Saturating negation just above +pi/2
    accept(1'b1, 16'h8000, 16'h0010, 16'h0193);
    expect_core("sat", 1'b1, 16'h7FFF, 16'hFFF0, 16'hFE6F);
    expect_result("sat", 16'h7F00, 16'hFE6F, 1'b1);

    // Exactly +pi/2: no fold
    accept(1'b1, 16'h8000, 16'h0010, 16'h0192);
    expect_core("pi2", 1'b1, 16'h8000, 16'h0010, 16'h0192);
    expect_result("pi2", 16'h80FF, 16'h0192, 1'b0);

    // Just below -pi/2
    accept(1'b1, 16'h0100, 16'h0000, 16'hFE6D);
    expect_core("negpi2", 1'b1, 16'hFF00, 16'h0000, 16'h0191);
    expect_result("negpi2", 16'hFFFF, 16'h0191, 1'b1);

    // Vectoring with x=0: pass through
    accept(1'b0, 16'h0000, 16'h0005, 16'h0010);
    expect_core("vecpass", 1'b0, 16'h0000, 16'h0005, 16'h0010);
    expect_result("vecpass", 16'h00FF, 16'h0010, 1'b0);

    // Abort in RUN at counter=5
    accept(1'b1, 16'h0100, 16'h0000, 16'h0000);
    repeat (6) @(negedge clk);
    check("run_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_res1", out_res1, 16'h0);
    check("abort_core_x", core_x, 16'h0);
    check("abort_core_mode", core_mode, 1'b0);
    check("abort_core_reset", core_reset, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    accept(1'b1, 16'hF994, 16'h1EC1, 16'h0200);
    expect_core("after", 1'b1, 16'h066C, 16'hE13F, 16'hFEDC);
    expect_result("after", 16'h0693, 16'hFEDC, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
